// File: rtl/imm_encoder.sv
// Purpose: pack a 32-bit immediate or PC-relative offset into the instr[31:7] field of one format.
// Latency: 2 cycles from accept to out_valid; throughput one request per cycle.
// Backpressure: valid/ready; stage 1 advances only when stage 2 is empty or drained.
module imm_encoder #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           sext_op,
    input  logic                 rel,
    input  logic [31:0]          target,
    input  logic [31:0]          pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [24:0]          dout,
    output logic [31:0]          imm,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // Immediate format codes shared with the sign-extension unit
    localparam logic [2:0] SEXT_I     = 3'd0;
    localparam logic [2:0] SEXT_S     = 3'd1;
    localparam logic [2:0] SEXT_B     = 3'd2;
    localparam logic [2:0] SEXT_J     = 3'd3;
    localparam logic [2:0] SEXT_U     = 3'd4;
    localparam logic [2:0] SEXT_SHIFT = 3'd5;

    // Stage 1: captured op and computed immediate
    logic                 s1_valid_q, s1_valid_d;
    logic [2:0]           s1_op_q, s1_op_d;
    logic [31:0]          s1_imm_q, s1_imm_d;

    // Stage 2: output registers
    logic                 out_valid_q, out_valid_d;
    logic [24:0]          dout_q, dout_d;
    logic [31:0]          imm_q, imm_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                 s2_adv;
    logic                 accept;
    logic [24:0]          pk_dout;
    logic                 pk_ok;
    logic signed [31:0]   s1_simm;

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign accept   = in_valid && in_ready;
    assign s1_simm  = $signed(s1_imm_q);

    // Field packing and representability check for the stage-1 immediate
    always_comb begin
        pk_dout = '0;
        pk_ok   = 1'b0;
        case (s1_op_q)
            SEXT_I: begin
                pk_dout[24:13] = s1_imm_q[11:0];
                pk_ok = (s1_simm >= -32'sd2048) && (s1_simm <= 32'sd2047);
            end
            SEXT_S: begin
                pk_dout[24:18] = s1_imm_q[11:5];
                pk_dout[4:0]   = s1_imm_q[4:0];
                pk_ok = (s1_simm >= -32'sd2048) && (s1_simm <= 32'sd2047);
            end
            SEXT_B: begin
                pk_dout[24]    = s1_imm_q[12];
                pk_dout[0]     = s1_imm_q[11];
                pk_dout[23:18] = s1_imm_q[10:5];
                pk_dout[4:1]   = s1_imm_q[4:1];
                pk_ok = (s1_simm >= -32'sd4096) && (s1_simm <= 32'sd4094) && !s1_imm_q[0];
            end
            SEXT_J: begin
                pk_dout[24]    = s1_imm_q[20];
                pk_dout[23:14] = s1_imm_q[10:1];
                pk_dout[13]    = s1_imm_q[11];
                pk_dout[12:5]  = s1_imm_q[19:12];
                pk_ok = (s1_simm >= -32'sd1048576) && (s1_simm <= 32'sd1048574) && !s1_imm_q[0];
            end
            SEXT_U: begin
                pk_dout[24:5] = s1_imm_q[31:12];
                pk_ok = (s1_imm_q[11:0] == 12'd0);
            end
            SEXT_SHIFT: begin
                pk_dout[17:13] = s1_imm_q[4:0];
                pk_ok = (s1_imm_q <= 32'd31);
            end
            default: begin
                pk_dout = '0;
                pk_ok   = 1'b0;
            end
        endcase
    end

    // Next-state for both pipeline stages and the error counter
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_imm_d    = s1_imm_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        imm_d       = imm_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_op_d  = sext_op;
            s1_imm_d = rel ? (target - pc) : target;
        end

        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                dout_d = pk_ok ? pk_dout : 25'd0;
                imm_d  = s1_imm_q;
                err_d  = !pk_ok;
            end
        end

        // Count errored results as they leave, pinned at all-ones
        if (out_valid_q && out_ready && err_q && !(&err_cnt_q)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= 3'd0;
            s1_imm_q    <= 32'd0;
            out_valid_q <= 1'b0;
            dout_q      <= 25'd0;
            imm_q       <= 32'd0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_imm_q    <= s1_imm_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            imm_q       <= imm_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign imm       = imm_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed format cases, ordered backpressure run, random run, reset flush.
// Expected results come from an instruction-format model and a queue scoreboard.
// A narrow error counter is used so saturation is reachable.
module tb_imm_encoder;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    sext_op = 3'd0;
    logic          rel = 1'b0;
    logic [31:0]   target = 32'd0;
    logic [31:0]   pc = 32'd0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [24:0]   dout;
    logic [31:0]   imm;
    logic          err;
    logic [CW-1:0] err_cnt;

    imm_encoder #(.ERR_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sext_op(sext_op), .rel(rel), .target(target), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .imm(imm), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [24:0] dout;
        logic [31:0] imm;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          model_cnt = 0;
    logic        held = 1'b0;
    logic [24:0] held_dout;
    logic [31:0] held_imm;
    logic        held_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: build the 32-bit instruction word in architectural layout, keep bits [31:7]
    function automatic exp_t model(input logic [2:0] op, input logic r,
                                   input logic [31:0] t, input logic [31:0] p);
        exp_t        e;
        logic [31:0] v;
        logic [31:0] ins;
        longint      s;
        logic        ok;
        v   = r ? t - p : t;
        s   = longint'($signed(v));
        ins = 32'd0;
        ok  = 1'b0;
        case (op)
            3'd0: begin ins[31:20] = v[11:0]; ok = (s >= -2048 && s <= 2047); end
            3'd1: begin ins[31:25] = v[11:5]; ins[11:7] = v[4:0]; ok = (s >= -2048 && s <= 2047); end
            3'd2: begin
                ins[31] = v[12]; ins[30:25] = v[10:5]; ins[11:8] = v[4:1]; ins[7] = v[11];
                ok = (s >= -4096 && s <= 4094 && v[0] == 1'b0);
            end
            3'd3: begin
                ins[31] = v[20]; ins[30:21] = v[10:1]; ins[20] = v[11]; ins[19:12] = v[19:12];
                ok = (s >= -1048576 && s <= 1048574 && v[0] == 1'b0);
            end
            3'd4: begin ins[31:12] = v[31:12]; ok = (v % 4096 == 0); end
            3'd5: begin ins[24:20] = v[4:0]; ok = (v <= 31); end
            default: ok = 1'b0;
        endcase
        e.op   = op;
        e.imm  = v;
        e.err  = !ok;
        e.dout = ok ? ins[31:7] : 25'd0;
        return e;
    endfunction

    // Sign-extender view of a packed field, for the round-trip property
    function automatic logic [31:0] sext(input logic [2:0] op, input logic [24:0] d);
        logic [31:0] ins;
        ins = {d, 7'd0};
        case (op)
            3'd0: return {{20{ins[31]}}, ins[31:20]};
            3'd1: return {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2: return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3: return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            3'd4: return {ins[31:12], 12'd0};
            3'd5: return {27'd0, ins[24:20]};
            default: return 32'd0;
        endcase
    endfunction

    // One cycle: drive at the falling edge, check settled outputs, then wait a cycle
    task automatic cyc(input logic iv, input logic [2:0] op, input logic r,
                       input logic [31:0] t, input logic [31:0] p, input logic ordy);
        exp_t e;
        int   s1_occ;
        in_valid  = iv;
        sext_op   = op;
        rel       = r;
        target    = t;
        pc        = p;
        out_ready = ordy;
        #1;
        chk("err_cnt", err_cnt, model_cnt);
        s1_occ = q.size() - (out_valid ? 1 : 0);
        chk("in_ready", in_ready, (s1_occ <= 0) || !out_valid || out_ready);
        if (held) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_dout", dout, held_dout);
            chk("stall_imm", imm, held_imm);
            chk("stall_err", err, held_err);
        end
        if (out_valid && out_ready) begin
            chk("out_has_item", q.size() != 0, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("dout", dout, e.dout);
                chk("imm", imm, e.imm);
                chk("err", err, e.err);
                if (!e.err) chk("roundtrip", sext(e.op, dout), e.imm);
                if (e.err && model_cnt < (1 << CW) - 1) model_cnt++;
            end
        end
        held      = out_valid && !out_ready;
        held_dout = dout;
        held_imm  = imm;
        held_err  = err;
        if (iv && in_ready) q.push_back(model(op, r, t, p));
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) cyc(0, 3'd0, 0, 0, 0, 1);
        chk("drained", q.size(), 0);
    endtask

    function automatic logic [31:0] rnd_target();
        case ($urandom_range(0, 5))
            0: return $urandom;
            1: return 32'($urandom_range(0, 10000)) - 32'd5000;
            2: return 32'h000F_FFFE + 32'($urandom_range(0, 4)) - 32'd2;
            3: return 32'hFFF0_0000 + 32'($urandom_range(0, 4)) - 32'd2;
            4: return $urandom & 32'hFFFF_F000;
            default: return 32'($urandom_range(0, 40));
        endcase
    endfunction

    initial begin
        logic [2:0]  rop;
        logic        rr;
        logic [31:0] rt;
        logic [31:0] rp;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_imm", imm, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Accept-to-valid latency of two cycles
        cyc(1, 3'd0, 0, 32'd5, 0, 1);
        chk("lat_cycle1", out_valid, 0);
        cyc(0, 3'd0, 0, 0, 0, 1);
        chk("lat_cycle2", out_valid, 1);
        drain();

        // Directed format cases
        cyc(1, 3'd0, 0, 32'hFFFF_F800, 0, 1);
        cyc(1, 3'd0, 0, 32'd2048, 0, 1);
        cyc(1, 3'd1, 0, 32'hFFFF_F801, 0, 1);
        cyc(1, 3'd2, 1, 32'h0000_00F0, 32'h100, 1);
        cyc(1, 3'd2, 0, 32'd4094, 0, 1);
        cyc(1, 3'd2, 0, 32'd4096, 0, 1);
        cyc(1, 3'd3, 1, 32'h0010_0000, 0, 1);
        cyc(1, 3'd3, 1, 32'd3, 0, 1);
        cyc(1, 3'd3, 0, 32'hFFF0_0000, 0, 1);
        cyc(1, 3'd4, 0, 32'h1234_5000, 0, 1);
        cyc(1, 3'd5, 0, 32'd40, 0, 1);
        cyc(1, 3'd5, 0, 32'd31, 0, 1);
        cyc(1, 3'd6, 0, 32'd0, 0, 1);
        cyc(1, 3'd7, 0, 32'd0, 0, 1);
        drain();

        // Back-to-back requests with out_ready pattern 1,0,0,1
        for (int i = 0; i < 8; i++)
            cyc(1, 3'd0, 0, 32'(i * 100 - 300), 0, (i % 4 == 0) || (i % 4 == 3));
        for (int i = 0; i < 8; i++)
            cyc(0, 3'd0, 0, 0, 0, (i % 4 == 0) || (i % 4 == 3));
        drain();

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            rop = 3'($urandom_range(0, 7));
            rr  = 1'($urandom_range(0, 1));
            rt  = rnd_target();
            rp  = rr ? 32'($urandom_range(0, 64)) * 2 : $urandom;
            cyc(1'($urandom_range(0, 3) != 0), rop, rr, rt, rp, 1'($urandom_range(0, 2) != 0));
        end
        drain();

        // Reset with two items in flight
        cyc(1, 3'd5, 0, 32'd99, 0, 0);
        cyc(1, 3'd5, 0, 32'd98, 0, 0);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        model_cnt = 0;
        held = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_err_cnt", err_cnt, 0);
        chk("flush_in_ready", in_ready, 1);
        @(negedge clk);
        repeat (3) cyc(0, 3'd0, 0, 0, 0, 1);
        chk("flush_no_ghost", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Hard bound on run time
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1);
    end

endmodule
